// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive peripheral: register map, STATUS bits,
// receive FSM states and the DIV clamp helper.
package uart_rx_pkg;

  // Word indices decoded from address bits [3:2]
  localparam logic [1:0] RegDataIdx   = 2'd0;
  localparam logic [1:0] RegStatusIdx = 2'd1;
  localparam logic [1:0] RegDivIdx    = 2'd2;

  localparam int unsigned BitNotEmpty = 0;
  localparam int unsigned BitFull     = 1;
  localparam int unsigned BitOverrun  = 2;
  localparam int unsigned BitFrameErr = 3;

  localparam logic [15:0] DivMin = 16'd4;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < DivMin) ? DivMin : value;
  endfunction

endpackage

// File: rtl/uart_rx_ip_fifo.sv
// Synchronous FIFO with extra pointer MSB to tell full from empty; a push while
// full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [AddrW:0]   wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign head_o  = mem_q[rptr_q[AddrW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_ip.sv
// Memory-mapped 8N1 UART receiver: input synchronizer, receive FSM with bit-period
// counter, receive FIFO and DATA/STATUS/DIV register interface.
module uart_rx_ip
  import uart_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd217
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic [3:0]  wstrb,
  output logic        wready,
  input  logic [31:0] raddr,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic        i_uart_rx,
  output logic        o_rx_irq
);

  logic [1:0]  sync_q;
  logic        rx_s, rx_prev_q, fall, expired;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d, div_lat_q, div_lat_d, div_q;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d, fifo_head;
  logic        rx_push, frame_set, fifo_full, fifo_empty, pop;
  logic        overrun_q, frame_err_q, wr_hit, clr_ovr, clr_frame, ovr_set;
  logic [31:0] rdata_d, rdata_q, status;
  logic        rvalid_q, wready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], i_uart_rx};
      rx_prev_q <= rx_s;
    end
  end

  assign rx_s    = sync_q[1];
  assign fall    = rx_prev_q & ~rx_s;
  assign expired = (cnt_q == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      div_lat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      div_lat_q <= div_lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (fall) state_d = StStart;
      StStart: if (expired) state_d = rx_s ? StIdle : StData;
      StData:  if (expired && bit_q == 3'd7) state_d = StStop;
      StStop:  if (expired) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Counter/shift datapath and the push / frame-error strobes
  always_comb begin
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    div_lat_d = div_lat_q;
    rx_push   = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (fall) begin
          cnt_d     = div_q >> 1;
          div_lat_d = div_q;
        end
      end
      StStart: begin
        if (expired) begin
          cnt_d = div_lat_q - 16'd1;
          bit_d = 3'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (expired) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = div_lat_q - 16'd1;
          bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (expired) begin
          rx_push   = rx_s;
          frame_set = ~rx_s;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: ;
    endcase
  end

  sync_fifo #(
    .Width(8),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign wr_hit    = wen & wstrb[0];
  assign clr_ovr   = wr_hit && waddr[3:2] == RegStatusIdx && wdata[BitOverrun];
  assign clr_frame = wr_hit && waddr[3:2] == RegStatusIdx && wdata[BitFrameErr];
  assign pop       = ren && raddr[3:2] == RegDataIdx && !fifo_empty;
  // A same-cycle pop frees the slot, so only an unrelieved full push overruns
  assign ovr_set   = rx_push & fifo_full & ~pop;

  always_comb begin
    status              = '0;
    status[BitNotEmpty] = ~fifo_empty;
    status[BitFull]     = fifo_full;
    status[BitOverrun]  = overrun_q;
    status[BitFrameErr] = frame_err_q;
    case (raddr[3:2])
      RegDataIdx:   rdata_d = fifo_empty ? 32'd0 : {24'd0, fifo_head};
      RegStatusIdx: rdata_d = status;
      RegDivIdx:    rdata_d = {16'd0, div_q};
      default:      rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= DIV_RESET;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      wready_q    <= 1'b0;
    end else begin
      if (wr_hit && waddr[3:2] == RegDivIdx) div_q <= clamp_div(wdata[15:0]);
      overrun_q   <= ovr_set | (overrun_q & ~clr_ovr);
      frame_err_q <= frame_set | (frame_err_q & ~clr_frame);
      if (ren) rdata_q <= rdata_d;
      rvalid_q    <= ren;
      wready_q    <= wen;
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign wready   = wready_q;
  assign o_rx_irq = ~fifo_empty;

  logic unused_bus;
  assign unused_bus = ^{waddr[31:4], waddr[1:0], wdata[31:16], wstrb[3:1],
                        raddr[31:4], raddr[1:0]};

endmodule
